// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair. Each result is computed
// when the operation is accepted and committed to HI/LO after a fixed busy window.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  op_t         op_sel;
  logic [3:0]  count_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] pend_hi_reg, pend_lo_reg;
  logic        pend_ok_reg;

  logic        is_signed, is_md, accept;
  logic        a_neg, b_neg;
  logic [63:0] mul_a, mul_b, product_next;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;
  logic [31:0] quot_next, rem_next;

  assign op_sel    = op_t'(op);
  assign is_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
  assign is_md     = (op_sel == OP_MULT) || (op_sel == OP_MULTU) ||
                     (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
  assign accept    = start && (count_reg == 4'd0);

  // Sign-extending for MULT makes the low 64 bits of one multiplier correct for both forms.
  assign mul_a        = {{32{is_signed & a[31]}}, a};
  assign mul_b        = {{32{is_signed & b[31]}}, b};
  assign product_next = mul_a * mul_b;

  // Divide on magnitudes, then restore signs; this also yields 0x80000000 / -1 = 0x80000000.
  always_comb begin
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (32'd0 - a) : a;
    b_mag     = b_neg ? (32'd0 - b) : b;
    b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_div;
    r_mag     = a_mag % b_div;
    quot_next = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem_next  = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= 4'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_ok_reg <= 1'b0;
    end else if (count_reg != 4'd0) begin
      count_reg <= count_reg - 4'd1;
      if (count_reg == 4'd1 && pend_ok_reg) begin
        hi_reg <= pend_hi_reg;
        lo_reg <= pend_lo_reg;
      end
    end else if (accept) begin
      case (op_sel)
        OP_MULT, OP_MULTU: begin
          pend_hi_reg <= product_next[63:32];
          pend_lo_reg <= product_next[31:0];
          pend_ok_reg <= 1'b1;
          count_reg   <= MUL_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi_reg <= rem_next;
          pend_lo_reg <= quot_next;
          pend_ok_reg <= (b != 32'd0);
          count_reg   <= DIV_LOAD;
        end
        OP_MTHI: hi_reg <= a;
        OP_MTLO: lo_reg <= a;
        default: ;
      endcase
    end
  end

  assign busy      = (count_reg != 4'd0);
  assign stall_req = busy | (start & is_md);
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule
